// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU/register sequencer: command opcodes, FSM states
// and datapath width defaults.
package alu_seq_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_OC_W  = 3;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_ALU  = 3'd3,
    OP_INC  = 3'd4,
    OP_DEC  = 3'd5,
    OP_SHR  = 3'd6,
    OP_SHL  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_shift(input op_t op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/alu_seq_step_cnt.sv
// Loadable down-counter for multi-step shift commands; zero flags that no
// further steps remain after the current one.
module alu_seq_step_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] din,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= din;
    end else if (dec) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_reg_sequencer.sv
// Command-driven sequencer for the ALU + control register accumulator pair.
// Optional build macro ALU_SEQ_PERF_EN adds a saturating done counter perf_cnt.
module alu_reg_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OC_W  = DEF_OC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [OC_W-1:0]  cmd_arg,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [OC_W-1:0]  alu_oc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_f,
  output logic             reg_cl,
  output logic             reg_ld,
  output logic             reg_inc,
  output logic             reg_dec,
  output logic             reg_sr,
  output logic             reg_ir,
  output logic             reg_sl,
  output logic             reg_il,
  output logic [WIDTH-1:0] reg_in,
  input  logic [WIDTH-1:0] reg_out,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [7:0]       perf_cnt
`endif
);

  state_t           state, state_nxt;
  op_t              op_q;
  logic [OC_W-1:0]  arg_q;
  logic [WIDTH-1:0] imm_q;
  logic             accept;
  logic             cnt_dec;
  logic             cnt_zero;
  op_t              cmd_op_e;

  assign cmd_op_e = op_t'(cmd_op);
  assign accept   = cmd_valid && (state == S_IDLE);

  // Counter holds the number of shift steps still to come after the current
  // one, so zero marks the final step.
  alu_seq_step_cnt #(.WIDTH(WIDTH)) u_step_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .dec  (cnt_dec),
    .din  (cmd_imm - WIDTH'(1)),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_NOP;
      arg_q <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= cmd_op_e;
      arg_q <= cmd_arg;
      imm_q <= cmd_imm;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_dec   = 1'b0;
    reg_cl    = 1'b0;
    reg_ld    = 1'b0;
    reg_inc   = 1'b0;
    reg_dec   = 1'b0;
    reg_sr    = 1'b0;
    reg_ir    = 1'b0;
    reg_sl    = 1'b0;
    reg_il    = 1'b0;
    reg_in    = '0;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op_e == OP_NOP || (is_shift(cmd_op_e) && cmd_imm == '0)) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        state_nxt = S_DONE;
        case (op_q)
          OP_CLR:  reg_cl  = 1'b1;
          OP_LOAD: begin
            reg_ld = 1'b1;
            reg_in = imm_q;
          end
          OP_ALU:  begin
            reg_ld = 1'b1;
            reg_in = alu_f;
          end
          OP_INC:  reg_inc = 1'b1;
          OP_DEC:  reg_dec = 1'b1;
          OP_SHR:  begin
            reg_sr = 1'b1;
            reg_ir = arg_q[0];
            if (!cnt_zero) begin
              state_nxt = S_EXEC;
              cnt_dec   = 1'b1;
            end
          end
          OP_SHL:  begin
            reg_sl = 1'b1;
            reg_il = arg_q[0];
            if (!cnt_zero) begin
              state_nxt = S_EXEC;
              cnt_dec   = 1'b1;
            end
          end
          default: ;
        endcase
      end

      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign result    = done ? reg_out : '0;
  assign alu_a     = reg_out;
  assign alu_oc    = arg_q;
  assign alu_b     = imm_q;

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (done && perf_cnt != 8'hFF) begin
      perf_cnt <= perf_cnt + 8'd1;
    end
  end
`endif

endmodule
